// File: rtl/ram_sp_fifo_ctrl_64x23_if.sv
// Stream-side interface of the RAM-backed FIFO controller: push channel,
// pop channel and fill level. The controller takes the slave view; the
// producer/consumer side takes the master view.
interface ram_sp_fifo_ctrl_64x23_if #(
  parameter int unsigned DAT_WD = 23,
  parameter int unsigned LVL_WD = 7
);
  logic              in_valid_i;
  logic [DAT_WD-1:0] in_dat_i;
  logic              in_ready_o;
  logic              out_valid_o;
  logic [DAT_WD-1:0] out_dat_o;
  logic              out_ready_i;
  logic [LVL_WD-1:0] lvl_o;

  modport master (
    output in_valid_i,
    output in_dat_i,
    output out_ready_i,
    input  in_ready_o,
    input  out_valid_o,
    input  out_dat_o,
    input  lvl_o
  );

  modport slave (
    input  in_valid_i,
    input  in_dat_i,
    input  out_ready_i,
    output in_ready_o,
    output out_valid_o,
    output out_dat_o,
    output lvl_o
  );
endinterface

// File: rtl/ram_sp_fifo_ctrl_64x23.sv
// Valid/ready FIFO controller in front of a single-port RAM (ram_sp_be_64x23).
// Pushes and pops share the one RAM port; a 2-entry output buffer prefetches
// RAM words to hide the 1-cycle read latency. Capacity is RAM depth + 2.
module ram_sp_fifo_ctrl_64x23 #(
  parameter int unsigned ADR_WD = 6,
  parameter int unsigned DAT_WD = 23
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr_i,
  ram_sp_fifo_ctrl_64x23_if.slave    s_if,
  output logic [ADR_WD-1:0]          ram_adr_o,
  output logic                       ram_wr_ena_o,
  output logic [DAT_WD-1:0]          ram_wr_dat_o,
  output logic                       ram_rd_ena_o,
  input  logic [DAT_WD-1:0]          ram_rd_dat_i
);

  localparam int unsigned CNT_WD = ADR_WD + 1;
  localparam logic [CNT_WD-1:0] RAM_DEPTH = CNT_WD'(2**ADR_WD);

  typedef enum logic {
    PRIO_WR = 1'b0,
    PRIO_RD = 1'b1
  } prio_t;

  logic [ADR_WD-1:0] wr_ptr;
  logic [ADR_WD-1:0] rd_ptr;
  logic [ADR_WD-1:0] adr_q;
  logic [CNT_WD-1:0] ram_cnt;
  logic              rd_inflight;
  logic [1:0]        obuf_cnt;
  logic [DAT_WD-1:0] obuf [2];
  prio_t             prio;

  logic              live;
  logic              ram_full;
  logic [2:0]        pend;
  logic              want_rd;
  logic              want_wr;
  logic              grant_wr;
  logic              grant_rd;
  logic              contested;
  logic              pop;
  logic [1:0]        fill_idx;

  // Port arbitration: one RAM access per cycle, alternating priority on contention
  always_comb begin
    live      = !rst && !clr_i;
    ram_full  = (ram_cnt == RAM_DEPTH);
    pend      = {1'b0, obuf_cnt} + {2'b00, rd_inflight};
    want_rd   = (ram_cnt != '0) && (pend < 3'd2);
    want_wr   = s_if.in_valid_i && !ram_full;
    grant_wr  = live && want_wr && !(want_rd && (prio == PRIO_RD));
    grant_rd  = live && want_rd && !(want_wr && (prio == PRIO_WR));
    contested = live && want_wr && want_rd;
    pop       = s_if.out_valid_o && s_if.out_ready_i;
    // Tail slot for an arriving RAM word, accounting for a same-cycle pop shift
    fill_idx  = obuf_cnt - {1'b0, pop};
  end

  // RAM port drive; the address holds its last value on idle cycles
  always_comb begin
    ram_wr_ena_o = grant_wr;
    ram_rd_ena_o = grant_rd;
    ram_wr_dat_o = s_if.in_dat_i;
    if (grant_wr) begin
      ram_adr_o = wr_ptr;
    end else if (grant_rd) begin
      ram_adr_o = rd_ptr;
    end else begin
      ram_adr_o = adr_q;
    end
  end

  // Stream-side outputs; in_ready does not look at in_valid
  always_comb begin
    s_if.in_ready_o  = live && !ram_full && !(want_rd && (prio == PRIO_RD));
    s_if.out_valid_o = (obuf_cnt != 2'd0);
    s_if.out_dat_o   = obuf[0];
    s_if.lvl_o       = ram_cnt + CNT_WD'(rd_inflight) + CNT_WD'(obuf_cnt);
  end

  // RAM-side bookkeeping: pointers, word count, read-in-flight flag, priority
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      adr_q       <= '0;
      ram_cnt     <= '0;
      rd_inflight <= 1'b0;
      prio        <= PRIO_WR;
    end else begin
      adr_q       <= ram_adr_o;
      rd_inflight <= grant_rd;
      ram_cnt     <= ram_cnt + CNT_WD'(grant_wr) - CNT_WD'(grant_rd);
      if (grant_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (grant_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (contested) begin
        prio <= (prio == PRIO_WR) ? PRIO_RD : PRIO_WR;
      end
    end
  end

  // Output buffer: shift on pop, then land the returning RAM word at the tail
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      obuf_cnt <= 2'd0;
      obuf[0]  <= '0;
      obuf[1]  <= '0;
    end else begin
      obuf_cnt <= obuf_cnt + {1'b0, rd_inflight} - {1'b0, pop};
      if (pop) begin
        obuf[0] <= obuf[1];
      end
      // Later assignment wins when the fill lands in the slot just vacated
      if (rd_inflight) begin
        obuf[fill_idx[0]] <= ram_rd_dat_i;
      end
    end
  end

endmodule

// File: tb/tb_ram_sp_fifo_ctrl_64x23.sv
// Directed bench for ram_sp_fifo_ctrl_64x23 with a behavioural single-port
// RAM (1-cycle registered read) and a data scoreboard on the stream ports.
module tb_ram_sp_fifo_ctrl_64x23;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr_i;
  logic [5:0]  ram_adr_o;
  logic        ram_wr_ena_o;
  logic [22:0] ram_wr_dat_o;
  logic        ram_rd_ena_o;
  logic [22:0] ram_rd_dat_i;

  ram_sp_fifo_ctrl_64x23_if #(.DAT_WD(23), .LVL_WD(7)) s_if ();

  ram_sp_fifo_ctrl_64x23 #(.ADR_WD(6), .DAT_WD(23)) dut (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (clr_i),
    .s_if         (s_if),
    .ram_adr_o    (ram_adr_o),
    .ram_wr_ena_o (ram_wr_ena_o),
    .ram_wr_dat_o (ram_wr_dat_o),
    .ram_rd_ena_o (ram_rd_ena_o),
    .ram_rd_dat_i (ram_rd_dat_i)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: write-enable stores, read-enable returns data next cycle
  logic [22:0] mem [64];
  always @(posedge clk) begin
    if (ram_wr_ena_o) mem[ram_adr_o] <= ram_wr_dat_o;
    if (ram_rd_ena_o) ram_rd_dat_i <= mem[ram_adr_o];
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard and port monitors
  logic [22:0] sb [$];
  int both_ena = 0;
  int wr_wraps = 0;
  int rd_wraps = 0;
  int last_wr  = -1;
  int last_rd  = -1;

  always @(negedge clk) begin
    if (ram_wr_ena_o && ram_rd_ena_o) both_ena++;
    if (ram_wr_ena_o) begin
      if (last_wr == 63 && ram_adr_o == 6'd0) wr_wraps++;
      last_wr = int'(ram_adr_o);
    end
    if (ram_rd_ena_o) begin
      if (last_rd == 63 && ram_adr_o == 6'd0) rd_wraps++;
      last_rd = int'(ram_adr_o);
    end
    if (rst || clr_i) begin
      sb.delete();
    end else begin
      if (s_if.in_valid_i && s_if.in_ready_o) sb.push_back(s_if.in_dat_i);
      if (s_if.out_valid_o && s_if.out_ready_i) begin
        if (sb.size() == 0) check("sb_underrun", 32'd1, 32'd0);
        else check("sb_data", {9'd0, s_if.out_dat_o}, {9'd0, sb.pop_front()});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int acc;
    int idx;
    int n;
    int alt_err;
    logic prev_wr;
    logic seen;

    rst = 1'b1;
    clr_i = 1'b0;
    s_if.in_valid_i = 1'b0;
    s_if.in_dat_i = '0;
    s_if.out_ready_i = 1'b0;

    // 1. Reset
    tick();
    @(negedge clk);
    check("rst_in_ready", {31'd0, s_if.in_ready_o}, 32'd0);
    check("rst_out_valid", {31'd0, s_if.out_valid_o}, 32'd0);
    check("rst_lvl", {25'd0, s_if.lvl_o}, 32'd0);
    check("rst_wr_ena", {31'd0, ram_wr_ena_o}, 32'd0);
    check("rst_rd_ena", {31'd0, ram_rd_ena_o}, 32'd0);
    tick();
    rst = 1'b0;

    // 2. Single word, c0 is the first cycle after reset
    s_if.in_valid_i = 1'b1;
    s_if.in_dat_i = 23'h5A5A5;
    s_if.out_ready_i = 1'b1;
    @(negedge clk);
    check("c0_in_ready", {31'd0, s_if.in_ready_o}, 32'd1);
    check("c0_wr_ena", {31'd0, ram_wr_ena_o}, 32'd1);
    check("c0_adr", {26'd0, ram_adr_o}, 32'd0);
    check("c0_lvl", {25'd0, s_if.lvl_o}, 32'd0);
    tick();
    s_if.in_valid_i = 1'b0;
    @(negedge clk);
    check("c1_rd_ena", {31'd0, ram_rd_ena_o}, 32'd1);
    check("c1_out_valid", {31'd0, s_if.out_valid_o}, 32'd0);
    check("c1_lvl", {25'd0, s_if.lvl_o}, 32'd1);
    tick();
    @(negedge clk);
    check("c2_out_valid", {31'd0, s_if.out_valid_o}, 32'd0);
    check("c2_lvl", {25'd0, s_if.lvl_o}, 32'd1);
    check("c2_idle_en", {30'd0, ram_wr_ena_o, ram_rd_ena_o}, 32'd0);
    tick();
    @(negedge clk);
    check("c3_out_valid", {31'd0, s_if.out_valid_o}, 32'd1);
    check("c3_out_dat", {9'd0, s_if.out_dat_o}, 32'h5A5A5);
    tick();
    @(negedge clk);
    check("c4_lvl", {25'd0, s_if.lvl_o}, 32'd0);
    check("c4_out_valid", {31'd0, s_if.out_valid_o}, 32'd0);
    tick();

    // 3. Fill to capacity with 70 offered words, then drain in order
    s_if.out_ready_i = 1'b0;
    k = 0;
    for (int c = 0; c < 200; c++) begin
      s_if.in_valid_i = (k < 70);
      s_if.in_dat_i = 23'(k);
      @(negedge clk);
      if (s_if.in_valid_i && s_if.in_ready_o) k++;
      tick();
    end
    @(negedge clk);
    check("fill_accepted", k, 32'd66);
    check("fill_lvl", {25'd0, s_if.lvl_o}, 32'd66);
    check("fill_in_ready", {31'd0, s_if.in_ready_o}, 32'd0);
    tick();
    s_if.in_valid_i = 1'b0;
    s_if.out_ready_i = 1'b1;
    idx = 0;
    for (int c = 0; c < 400 && idx < 66; c++) begin
      @(negedge clk);
      if (s_if.out_valid_o) begin
        check("fill_order", {9'd0, s_if.out_dat_o}, idx);
        idx++;
      end
      tick();
    end
    check("drain_count", idx, 32'd66);
    @(negedge clk);
    check("drain_lvl", {25'd0, s_if.lvl_o}, 32'd0);
    tick();

    // 4. Contention: prefill 10, then continuous push and pop
    s_if.out_ready_i = 1'b0;
    n = 0;
    for (int c = 0; c < 100 && n < 10; c++) begin
      s_if.in_valid_i = 1'b1;
      s_if.in_dat_i = 23'h100 + 23'(n);
      @(negedge clk);
      if (s_if.in_ready_o) n++;
      tick();
    end
    s_if.in_valid_i = 1'b0;
    repeat (6) tick();
    @(negedge clk);
    check("pre_lvl", {25'd0, s_if.lvl_o}, 32'd10);
    tick();
    s_if.in_valid_i = 1'b1;
    s_if.out_ready_i = 1'b1;
    acc = 0;
    alt_err = 0;
    prev_wr = 1'b0;
    for (int c = 0; c < 30; c++) begin
      s_if.in_dat_i = 23'h200 + 23'(acc);
      @(negedge clk);
      if (s_if.in_ready_o) acc++;
      if (c >= 3) begin
        if (ram_wr_ena_o == ram_rd_ena_o) alt_err++;
        if (c > 3 && ram_wr_ena_o == prev_wr) alt_err++;
      end
      prev_wr = ram_wr_ena_o;
      tick();
    end
    check("alternate", alt_err, 32'd0);
    s_if.in_valid_i = 1'b0;
    for (int c = 0; c < 200 && s_if.lvl_o != 7'd0; c++) tick();
    check("cont_lvl", {25'd0, s_if.lvl_o}, 32'd0);
    tick();
    check("cont_sb_empty", sb.size(), 32'd0);

    // 5. Random valid/ready over 200 words with pointer wrap
    wr_wraps = 0;
    rd_wraps = 0;
    n = 0;
    for (int c = 0; c < 5000 && (n < 200 || s_if.lvl_o != 7'd0); c++) begin
      s_if.in_valid_i = (n < 200) && ($urandom_range(0, 3) != 0);
      s_if.in_dat_i = 23'($urandom);
      s_if.out_ready_i = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (s_if.in_valid_i && s_if.in_ready_o) n++;
      tick();
    end
    s_if.in_valid_i = 1'b0;
    check("rand_pushed", n, 32'd200);
    check("rand_lvl", {25'd0, s_if.lvl_o}, 32'd0);
    check("wr_wraps_ge3", {31'd0, wr_wraps >= 3}, 32'd1);
    check("rd_wraps_ge3", {31'd0, rd_wraps >= 3}, 32'd1);
    tick();
    check("rand_sb_empty", sb.size(), 32'd0);

    // 6. Flush with a RAM read in flight while 5 words are held
    s_if.out_ready_i = 1'b0;
    n = 0;
    for (int c = 0; c < 50 && n < 5; c++) begin
      s_if.in_valid_i = 1'b1;
      s_if.in_dat_i = 23'h300 + 23'(n);
      @(negedge clk);
      if (s_if.in_ready_o) n++;
      tick();
    end
    s_if.in_valid_i = 1'b0;
    repeat (6) tick();
    @(negedge clk);
    check("fl_idle_lvl", {25'd0, s_if.lvl_o}, 32'd5);
    tick();
    s_if.in_valid_i = 1'b1;
    s_if.in_dat_i = 23'h305;
    s_if.out_ready_i = 1'b1;
    tick();
    s_if.in_valid_i = 1'b0;
    s_if.out_ready_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = ram_rd_ena_o;
      tick();
    end
    check("fl_read_seen", {31'd0, seen}, 32'd1);
    clr_i = 1'b1;
    @(negedge clk);
    check("fl_pre_lvl", {25'd0, s_if.lvl_o}, 32'd5);
    check("fl_in_ready", {31'd0, s_if.in_ready_o}, 32'd0);
    tick();
    clr_i = 1'b0;
    @(negedge clk);
    check("fl_out_valid", {31'd0, s_if.out_valid_o}, 32'd0);
    check("fl_lvl", {25'd0, s_if.lvl_o}, 32'd0);
    tick();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("fl_no_stale", {31'd0, s_if.out_valid_o}, 32'd0);
      tick();
    end
    s_if.in_valid_i = 1'b1;
    s_if.in_dat_i = 23'h0ABCD;
    s_if.out_ready_i = 1'b1;
    tick();
    s_if.in_valid_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (s_if.out_valid_o) begin
        seen = 1'b1;
        check("fl_first_out", {9'd0, s_if.out_dat_o}, 32'h0ABCD);
      end
      tick();
    end
    check("fl_out_seen", {31'd0, seen}, 32'd1);
    @(negedge clk);
    check("fl_end_lvl", {25'd0, s_if.lvl_o}, 32'd0);
    check("one_access", both_ena, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
